// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU op sequencer: op codes, FSM states, flag positions and decode selects.
// Thirteen ops occupy codes 0-12; codes 13-15 are illegal and complete with op_err set.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_ORA = 4'd4;
    localparam logic [3:0] OP_EOR = 4'd5;
    localparam logic [3:0] OP_ASL = 4'd6;
    localparam logic [3:0] OP_LSR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;
    localparam logic [3:0] OP_BIT = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Flag vector layout {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_NZCV = 4'b1111;
    localparam logic [3:0] MASK_NZC  = 4'b1110;
    localparam logic [3:0] MASK_NZV  = 4'b1101;
    localparam logic [3:0] MASK_NZ   = 4'b1100;

    typedef struct packed {
        logic sum;
        logic and_l;
        logic eor;
        logic or_l;
        logic asl;
        logic lsr;
        logic inv;
        logic rol;
        logic ror;
    } alu_en_t;

    typedef enum logic [1:0] {
        BSEL_OPB  = 2'd0,
        BSEL_ZERO = 2'd1,
        BSEL_ONES = 2'd2
    } bsel_e;

    typedef enum logic [1:0] {
        CSEL_OPC  = 2'd0,
        CSEL_ZERO = 2'd1,
        CSEL_ONE  = 2'd2
    } csel_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decode: ALU enables, B/Cin source selects, flag update mask and write-back.
// Zero latency, no state; illegal codes decode to no enables and an empty mask.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] op_code_i,
    output alu_en_t    en_o,
    output bsel_e      b_sel_o,
    output csel_e      cin_sel_o,
    output logic [3:0] mask_o,
    output logic       wb_o,
    output logic       bit_o,
    output logic       illegal_o
);

    always_comb begin
        en_o      = '0;
        b_sel_o   = BSEL_OPB;
        cin_sel_o = CSEL_ZERO;
        mask_o    = MASK_NZ;
        wb_o      = 1'b1;
        bit_o     = 1'b0;
        illegal_o = 1'b0;
        case (op_code_i)
            OP_ADC: begin en_o.sum = 1'b1; cin_sel_o = CSEL_OPC; mask_o = MASK_NZCV; end
            OP_SBC: begin en_o.sum = 1'b1; en_o.inv = 1'b1; cin_sel_o = CSEL_OPC; mask_o = MASK_NZCV; end
            // Compare is a subtract with borrow-in cleared and no write-back
            OP_CMP: begin en_o.sum = 1'b1; en_o.inv = 1'b1; cin_sel_o = CSEL_ONE; mask_o = MASK_NZC; wb_o = 1'b0; end
            OP_AND: en_o.and_l = 1'b1;
            OP_ORA: en_o.or_l  = 1'b1;
            OP_EOR: en_o.eor   = 1'b1;
            OP_ASL: begin en_o.asl = 1'b1; b_sel_o = BSEL_ZERO; mask_o = MASK_NZC; end
            OP_LSR: begin en_o.lsr = 1'b1; b_sel_o = BSEL_ZERO; mask_o = MASK_NZC; end
            OP_ROL: begin en_o.rol = 1'b1; b_sel_o = BSEL_ZERO; cin_sel_o = CSEL_OPC; mask_o = MASK_NZC; end
            OP_ROR: begin en_o.ror = 1'b1; b_sel_o = BSEL_ZERO; cin_sel_o = CSEL_OPC; mask_o = MASK_NZC; end
            OP_INC: begin en_o.sum = 1'b1; b_sel_o = BSEL_ZERO; cin_sel_o = CSEL_ONE; end
            OP_DEC: begin en_o.sum = 1'b1; b_sel_o = BSEL_ONES; end
            OP_BIT: begin en_o.and_l = 1'b1; mask_o = MASK_NZV; wb_o = 1'b0; bit_o = 1'b1; end
            default: begin
                b_sel_o   = BSEL_ZERO;
                mask_o    = MASK_NONE;
                wb_o      = 1'b0;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Runs one ALU op per request: IDLE accept -> one EXEC cycle driving the ALU -> DONE holding result and flags.
// Result valid the cycle after EXEC; DONE holds indefinitely until res_ready, 3 cycles per op back-to-back.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [3:0]   op_code,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_c,
    output logic         alu_sum_en,
    output logic         alu_and_en,
    output logic         alu_eor_en,
    output logic         alu_or_en,
    output logic         alu_asl_en,
    output logic         alu_lsr_en,
    output logic         alu_inv_en,
    output logic         alu_rol_en,
    output logic         alu_ror_en,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_cin,
    input  logic [W-1:0] alu_res,
    input  logic         alu_cout,
    input  logic         alu_ovf,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_wb,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_v,
    output logic [3:0]   flag_mask,
    output logic         op_err
);

    state_e       state_q;
    logic         op_ready_q;
    alu_en_t      en_q;
    logic [W-1:0] alu_a_q, alu_b_q, op_a_q;
    logic         alu_cin_q;
    logic [3:0]   mask_q;
    logic         wb_q, err_q, is_bit_q, bit_n_q, bit_v_q;
    logic         res_valid_q, res_wb_q, op_err_q;
    logic [W-1:0] res_data_q, res_data_d;
    logic [3:0]   flags_q, flags_d, flag_mask_q;

    alu_en_t      dec_en;
    bsel_e        dec_bsel;
    csel_e        dec_csel;
    logic [3:0]   dec_mask;
    logic         dec_wb, dec_bit, dec_illegal;
    logic [W-1:0] dec_b;
    logic         dec_cin;

    alu_op_decode u_decode (
        .op_code_i (op_code),
        .en_o      (dec_en),
        .b_sel_o   (dec_bsel),
        .cin_sel_o (dec_csel),
        .mask_o    (dec_mask),
        .wb_o      (dec_wb),
        .bit_o     (dec_bit),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        case (dec_bsel)
            BSEL_OPB:  dec_b = op_b;
            BSEL_ONES: dec_b = '1;
            default:   dec_b = '0;
        endcase
        case (dec_csel)
            CSEL_OPC: dec_cin = op_c;
            CSEL_ONE: dec_cin = 1'b1;
            default:  dec_cin = 1'b0;
        endcase
    end

    // BIT takes N/V straight from the memory operand rather than the AND result
    always_comb begin
        res_data_d      = err_q ? op_a_q : alu_res;
        flags_d         = '0;
        flags_d[FLAG_N] = is_bit_q ? bit_n_q : alu_res[W-1];
        flags_d[FLAG_Z] = (alu_res == '0);
        flags_d[FLAG_C] = alu_cout;
        flags_d[FLAG_V] = is_bit_q ? bit_v_q : alu_ovf;
        flags_d         = flags_d & mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_ready_q  <= 1'b1;
            en_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            op_a_q      <= '0;
            mask_q      <= '0;
            wb_q        <= 1'b0;
            err_q       <= 1'b0;
            is_bit_q    <= 1'b0;
            bit_n_q     <= 1'b0;
            bit_v_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_wb_q    <= 1'b0;
            flags_q     <= '0;
            flag_mask_q <= '0;
            op_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        state_q    <= ST_EXEC;
                        op_ready_q <= 1'b0;
                        en_q       <= dec_en;
                        alu_a_q    <= op_a;
                        alu_b_q    <= dec_b;
                        alu_cin_q  <= dec_cin;
                        op_a_q     <= op_a;
                        mask_q     <= dec_mask;
                        wb_q       <= dec_wb;
                        err_q      <= dec_illegal;
                        is_bit_q   <= dec_bit;
                        bit_n_q    <= op_b[W-1];
                        bit_v_q    <= op_b[W-2];
                    end
                end
                ST_EXEC: begin
                    state_q     <= ST_DONE;
                    en_q        <= '0;
                    alu_a_q     <= '0;
                    alu_b_q     <= '0;
                    alu_cin_q   <= 1'b0;
                    res_valid_q <= 1'b1;
                    res_data_q  <= res_data_d;
                    flags_q     <= flags_d;
                    flag_mask_q <= mask_q;
                    res_wb_q    <= wb_q;
                    op_err_q    <= err_q;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_q     <= ST_IDLE;
                        res_valid_q <= 1'b0;
                        op_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign op_ready   = op_ready_q;
    assign alu_sum_en = en_q.sum;
    assign alu_and_en = en_q.and_l;
    assign alu_eor_en = en_q.eor;
    assign alu_or_en  = en_q.or_l;
    assign alu_asl_en = en_q.asl;
    assign alu_lsr_en = en_q.lsr;
    assign alu_inv_en = en_q.inv;
    assign alu_rol_en = en_q.rol;
    assign alu_ror_en = en_q.ror;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cin    = alu_cin_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_wb     = res_wb_q;
    assign flag_n     = flags_q[FLAG_N];
    assign flag_z     = flags_q[FLAG_Z];
    assign flag_c     = flags_q[FLAG_C];
    assign flag_v     = flags_q[FLAG_V];
    assign flag_mask  = flag_mask_q;
    assign op_err     = op_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural 6502 ALU on the ALU port, random ops scored against an arithmetic model.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst, op_valid, op_ready, op_c;
    logic [3:0] op_code;
    logic [7:0] op_a, op_b;
    logic       alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_asl_en;
    logic       alu_lsr_en, alu_inv_en, alu_rol_en, alu_ror_en;
    logic [7:0] alu_a, alu_b, alu_res, bb;
    logic       alu_cin, alu_cout, alu_ovf;
    logic       res_valid, res_ready, res_wb, op_err;
    logic [7:0] res_data;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic [3:0] flag_mask;
    logic [8:0] en_v;
    logic [3:0] flags_v;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_acc = -1;

    localparam logic [8:0] E_SUM = 9'h100, E_AND = 9'h080, E_EOR = 9'h040, E_OR = 9'h020,
                           E_ASL = 9'h010, E_LSR = 9'h008, E_INV = 9'h004, E_ROL = 9'h002,
                           E_ROR = 9'h001;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_op_sequencer #(.W(8)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .alu_sum_en(alu_sum_en), .alu_and_en(alu_and_en), .alu_eor_en(alu_eor_en),
        .alu_or_en(alu_or_en), .alu_asl_en(alu_asl_en), .alu_lsr_en(alu_lsr_en),
        .alu_inv_en(alu_inv_en), .alu_rol_en(alu_rol_en), .alu_ror_en(alu_ror_en),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_res(alu_res),
        .alu_cout(alu_cout), .alu_ovf(alu_ovf), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_wb(res_wb), .flag_n(flag_n), .flag_z(flag_z),
        .flag_c(flag_c), .flag_v(flag_v), .flag_mask(flag_mask), .op_err(op_err)
    );

    assign en_v    = {alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_asl_en,
                      alu_lsr_en, alu_inv_en, alu_rol_en, alu_ror_en};
    assign flags_v = {flag_n, flag_z, flag_c, flag_v};

    // Combinational ALU the sequencer drives
    always_comb begin
        alu_res  = 8'h00;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        bb       = alu_inv_en ? ~alu_b : alu_b;
        if (alu_sum_en) begin
            {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, bb} + {8'h00, alu_cin};
            alu_ovf = (alu_a[7] == bb[7]) && (alu_res[7] != alu_a[7]);
        end else if (alu_and_en) alu_res = alu_a & alu_b;
        else if (alu_or_en)  alu_res = alu_a | alu_b;
        else if (alu_eor_en) alu_res = alu_a ^ alu_b;
        else if (alu_asl_en || alu_rol_en) {alu_cout, alu_res} = {alu_a, alu_cin};
        else if (alu_lsr_en || alu_ror_en) {alu_res, alu_cout} = {alu_cin, alu_a};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] res;
        logic [3:0] flags;
        logic [3:0] mask;
        logic       wb;
        logic       err;
        logic [8:0] en;
        logic [7:0] b;
        logic       cin;
    } exp_t;

    function automatic int sgn(input logic [7:0] x);
        return (int'(x) > 127) ? int'(x) - 256 : int'(x);
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic c);
        exp_t e;
        int ai, bi, ci, s, sv;
        logic n, z, cf, v;
        ai = int'(a); bi = int'(b); ci = int'(c);
        e.wb = 1'b1; e.err = 1'b0; e.b = b; e.cin = 1'b0; e.mask = MASK_NZ; e.en = '0;
        cf = 1'b0; v = 1'b0; e.res = 8'h00;
        case (op)
            OP_ADC: begin
                s = ai + bi + ci; sv = sgn(a) + sgn(b) + ci;
                e.res = 8'(s); cf = (s > 255); v = (sv > 127) || (sv < -128);
                e.mask = MASK_NZCV; e.en = E_SUM; e.cin = c;
            end
            OP_SBC: begin
                s = ai - bi - (1 - ci); sv = sgn(a) - sgn(b) - (1 - ci);
                e.res = 8'(s); cf = (s >= 0); v = (sv > 127) || (sv < -128);
                e.mask = MASK_NZCV; e.en = E_SUM | E_INV; e.cin = c;
            end
            OP_CMP: begin
                e.res = 8'(ai - bi); cf = (ai >= bi);
                e.mask = MASK_NZC; e.wb = 1'b0; e.en = E_SUM | E_INV; e.cin = 1'b1;
            end
            OP_AND: begin e.res = a & b; e.en = E_AND; end
            OP_ORA: begin e.res = a | b; e.en = E_OR; end
            OP_EOR: begin e.res = a ^ b; e.en = E_EOR; end
            OP_ASL: begin e.res = 8'(ai * 2); cf = a[7]; e.mask = MASK_NZC; e.en = E_ASL; e.b = 0; end
            OP_LSR: begin e.res = 8'(ai / 2); cf = a[0]; e.mask = MASK_NZC; e.en = E_LSR; e.b = 0; end
            OP_ROL: begin
                e.res = 8'(ai * 2 + ci); cf = a[7]; e.mask = MASK_NZC; e.en = E_ROL; e.b = 0; e.cin = c;
            end
            OP_ROR: begin
                e.res = 8'(ai / 2 + ci * 128); cf = a[0]; e.mask = MASK_NZC; e.en = E_ROR; e.b = 0; e.cin = c;
            end
            OP_INC: begin e.res = 8'(ai + 1); e.en = E_SUM; e.b = 8'h00; e.cin = 1'b1; end
            OP_DEC: begin e.res = 8'(ai - 1); e.en = E_SUM; e.b = 8'hFF; end
            OP_BIT: begin e.res = a & b; e.mask = MASK_NZV; e.wb = 1'b0; e.en = E_AND; end
            default: begin e.res = a; e.mask = MASK_NONE; e.wb = 1'b0; e.err = 1'b1; end
        endcase
        n = e.res[7];
        z = (e.res == 8'h00);
        if (op == OP_BIT) begin n = b[7]; v = b[6]; end
        e.flags = {n, z, cf, v} & e.mask;
        return e;
    endfunction

    task automatic check_reset_state();
        check_val("rst_op_ready", op_ready, 1);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_res_data", res_data, 0);
        check_val("rst_res_wb", res_wb, 0);
        check_val("rst_flags", flags_v, 0);
        check_val("rst_mask", flag_mask, 0);
        check_val("rst_op_err", op_err, 0);
        check_val("rst_alu_en", en_v, 0);
        check_val("rst_alu_ops", {alu_a, alu_b, alu_cin}, 0);
    endtask

    // Entered at #1 after an edge with the DUT in IDLE; leaves it in IDLE the same way
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input int hold);
        exp_t e;
        int t_acc;
        e = model(op, a, b, c);
        check_val("idle_ready", op_ready, 1);
        check_val("idle_en", en_v, 0);
        op_valid = 1'b1; op_code = op; op_a = a; op_b = b; op_c = c;
        @(posedge clk); #1;
        t_acc = cyc;
        op_valid = 1'b0; op_code = 4'($urandom); op_a = 8'($urandom); op_b = 8'($urandom);
        op_c = 1'($urandom);
        if (last_acc >= 0) check_val("throughput", t_acc - last_acc, 3);
        last_acc = t_acc;
        check_val("exec_en", en_v, e.en);
        if (!e.err) begin
            check_val("exec_alu_a", alu_a, a);
            check_val("exec_alu_b", alu_b, e.b);
            check_val("exec_cin", alu_cin, e.cin);
        end
        check_val("exec_ready", op_ready, 0);
        check_val("exec_valid", res_valid, 0);
        @(posedge clk); #1;
        check_val("done_valid", res_valid, 1);
        check_val("done_data", res_data, e.res);
        check_val("done_flags", flags_v, e.flags);
        check_val("done_mask", flag_mask, e.mask);
        check_val("done_wb", res_wb, e.wb);
        check_val("done_err", op_err, e.err);
        check_val("done_en", en_v, 0);
        check_val("done_alu_ops", {alu_a, alu_b, alu_cin}, 0);
        check_val("done_ready", op_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", res_valid, 1);
            check_val("hold_data", {res_data, flags_v, flag_mask, res_wb, op_err}, {e.res, e.flags, e.mask, e.wb, e.err});
            check_val("hold_ready", op_ready, 0);
        end
        // A request offered while the result is taken must not be accepted that cycle
        res_ready = 1'b1; op_valid = 1'b1; op_code = OP_ADC;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_val("release_valid", res_valid, 0);
        check_val("release_ready", op_ready, 1);
        check_val("release_en", en_v, 0);
        op_valid = 1'b0;
        if (hold != 0) last_acc = -1;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = 4'h0; op_a = 8'h00; op_b = 8'h00;
        op_c = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("post_rst_ready", op_ready, 1);

        run_op(OP_ADC, 8'h50, 8'h50, 1'b0, 0);
        run_op(OP_SBC, 8'h50, 8'h10, 1'b1, 0);
        run_op(OP_CMP, 8'h10, 8'h20, 1'b0, 0);
        run_op(OP_BIT, 8'h0F, 8'hC0, 1'b0, 0);
        run_op(OP_ROR, 8'h01, 8'h00, 1'b1, 0);
        run_op(OP_ASL, 8'h80, 8'h00, 1'b1, 0);
        run_op(OP_INC, 8'hFF, 8'h00, 1'b0, 0);
        run_op(OP_DEC, 8'h00, 8'h00, 1'b1, 0);
        run_op(OP_ADC, 8'h7F, 8'h80, 1'b1, 5);
        run_op(4'd13, 8'h5A, 8'h33, 1'b1, 0);

        // Reset in EXEC drops the op
        last_acc = -1;
        op_valid = 1'b1; op_code = OP_ORA; op_a = 8'h0F; op_b = 8'hF0; op_c = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        check_val("pre_rst_exec_en", en_v, E_OR);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state();
        @(posedge clk); #1;
        check_val("rst_no_valid", res_valid, 0);
        run_op(OP_EOR, 8'hFF, 8'h0F, 1'b0, 0);

        // Reset in DONE beats a simultaneous res_ready and op_valid
        last_acc = -1;
        op_valid = 1'b1; op_code = OP_LSR; op_a = 8'h03; op_b = 8'h00; op_c = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        check_val("pre_rst_done", res_valid, 1);
        rst = 1'b1; res_ready = 1'b1; op_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; res_ready = 1'b0; op_valid = 1'b0;
        check_reset_state();
        @(posedge clk); #1;
        last_acc = -1;

        for (int k = 0; k < 300; k++) begin
            run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
